// File: rtl/booth4_multiplier.sv
// rtl/booth4_multiplier.sv - radix-4 Booth sequential multiplier, signed/unsigned, WIDTH/2+1 cycles
module booth4_multiplier #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_start,
   input  logic                 op_clear,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   output logic                 op_busy,
   output logic                 op_done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int PW = 2*WIDTH;
   localparam int N  = WIDTH/2 + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH+2:0]  mq;    // extended multiplier with m[-1] at bit 0, shifted right 2 per step
   logic [PW-1:0]     mc;    // multiplicand times 4^i; bits above PW never reach the result
   logic [PW-1:0]     acc;
   logic [PW-1:0]     pp;
   logic              m_sx;
   logic              c_sx;

   assign m_sx = is_signed & multiplier[WIDTH-1];
   assign c_sx = is_signed & multiplicand[WIDTH-1];

   always_comb begin
      pp = '0;
      case (mq[2:0])
         3'b001, 3'b010: pp = mc;
         3'b011:         pp = mc << 1;
         3'b100:         pp = -(mc << 1);
         3'b101, 3'b110: pp = -mc;
         default:        pp = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         mq    <= '0;
         mc    <= '0;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!op_clear && op_start) begin
                  mq    <= {m_sx, m_sx, multiplier, 1'b0};
                  mc    <= {{WIDTH{c_sx}}, multiplicand};
                  acc   <= '0;
                  cnt   <= '0;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_clear) begin
                  state <= IDLE;
               end else begin
                  acc <= acc + pp;
                  mc  <= mc << 2;
                  mq  <= {mq[WIDTH+2], mq[WIDTH+2], mq[WIDTH+2:2]};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST)
                     state <= DONE;
               end
            end
            DONE: begin
               if (op_clear)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign op_busy = (state == EXEC);
   assign op_done = (state == DONE);
   assign result  = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_booth4_multiplier.sv
// tb/tb_booth4_multiplier.sv - bench for booth4_multiplier at WIDTH 8, 16 and 64
module tb_booth4_multiplier;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [2:0]   start = '0;
   logic [2:0]   clr = '0;
   logic [2:0]   sgn = '0;
   logic [7:0]   a8 = '0, b8 = '0;
   logic [15:0]  a16 = '0, b16 = '0;
   logic [63:0]  a64 = '0, b64 = '0;
   logic [2:0]   busy, done;
   logic [15:0]  r8;
   logic [31:0]  r16;
   logic [127:0] r64;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   booth4_multiplier #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .op_start(start[0]), .op_clear(clr[0]), .is_signed(sgn[0]),
      .multiplier(a8), .multiplicand(b8), .op_busy(busy[0]), .op_done(done[0]), .result(r8));
   booth4_multiplier #(.WIDTH(16), .CNT_W(5)) dut16 (
      .clk(clk), .reset_n(reset_n), .op_start(start[1]), .op_clear(clr[1]), .is_signed(sgn[1]),
      .multiplier(a16), .multiplicand(b16), .op_busy(busy[1]), .op_done(done[1]), .result(r16));
   booth4_multiplier #(.WIDTH(64), .CNT_W(7)) dut64 (
      .clk(clk), .reset_n(reset_n), .op_start(start[2]), .op_clear(clr[2]), .is_signed(sgn[2]),
      .multiplier(a64), .multiplicand(b64), .op_busy(busy[2]), .op_done(done[2]), .result(r64));

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int width_of(input int idx);
      return (idx == 0) ? 8 : (idx == 1) ? 16 : 64;
   endfunction

   function automatic logic [127:0] get_res(input int idx);
      case (idx)
         0:       return {112'd0, r8};
         1:       return {96'd0, r16};
         default: return r64;
      endcase
   endfunction

   // Exact product of the two w-bit operands, reduced to 2w bits
   function automatic logic [127:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic s);
      logic [129:0] mask, ea, eb, p;
      logic [127:0] rmask;
      mask = (130'd1 << w) - 130'd1;
      ea = {66'd0, a} & mask;
      eb = {66'd0, b} & mask;
      if (s && a[w-1]) ea = ea | ~mask;
      if (s && b[w-1]) eb = eb | ~mask;
      p = ea * eb;
      rmask = (w == 64) ? '1 : ((128'd1 << (2*w)) - 128'd1);
      return p[127:0] & rmask;
   endfunction

   function automatic logic [63:0] rnd(input int w);
      logic [63:0] r, mask;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      case ($urandom_range(0, 7))
         0:       r = '1;
         1:       r = 64'd1 << (w-1);
         2:       r = '0;
         3:       r = (64'd1 << (w-1)) - 64'd1;
         default: r = {$urandom, $urandom};
      endcase
      return r & mask;
   endfunction

   task automatic set_ops(input int idx, input logic [63:0] a, input logic [63:0] b, input logic s);
      sgn[idx] = s;
      case (idx)
         0:       begin a8 = a[7:0];   b8 = b[7:0];   end
         1:       begin a16 = a[15:0]; b16 = b[15:0]; end
         default: begin a64 = a;       b64 = b;       end
      endcase
   endtask

   task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b, input logic s,
                         input string tag);
      int w, n, nb;
      logic [127:0] exp;
      w = width_of(idx);
      exp = model(w, a, b, s);
      set_ops(idx, a, b, s);
      start[idx] = 1'b1;
      tick;
      start[idx] = 1'b0;
      set_ops(idx, rnd(w), rnd(w), ~s);
      n = 0;
      nb = 0;
      while (!done[idx] && n < 80) begin
         if (busy[idx]) nb++;
         tick;
         n++;
      end
      chk($sformatf("%s latency", tag), 128'(n), 128'(w/2 + 1));
      chk($sformatf("%s busy_cycles", tag), 128'(nb), 128'(w/2 + 1));
      chk($sformatf("%s result", tag), get_res(idx), exp);
   endtask

   task automatic clear_op(input int idx, input string tag);
      clr[idx] = 1'b1;
      tick;
      clr[idx] = 1'b0;
      chk($sformatf("%s clr_done", tag), 128'(done[idx]), 128'd0);
      chk($sformatf("%s clr_result", tag), get_res(idx), 128'd0);
   endtask

   initial begin
      #12;
      chk("reset busy", 128'(busy), 128'd0);
      chk("reset done", 128'(done), 128'd0);
      chk("reset r8", get_res(0), 128'd0);
      chk("reset r16", get_res(1), 128'd0);
      chk("reset r64", get_res(2), 128'd0);
      reset_n = 1'b1;
      tick;

      // 255 x 255 unsigned, then DONE must hold through ignored starts
      run_op(0, 64'hFF, 64'hFF, 1'b0, "u8 255x255");
      chk("u8 value", get_res(0), 128'hFE01);
      start[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("hold done", 128'(done[0]), 128'd1);
         chk("hold result", get_res(0), 128'hFE01);
      end
      start[0] = 1'b0;
      clear_op(0, "u8 255x255");

      run_op(0, 64'h80, 64'h80, 1'b1, "s8 -128x-128");
      chk("s8 -128x-128 value", get_res(0), 128'h4000);
      clear_op(0, "s8");
      run_op(0, 64'hFF, 64'h01, 1'b1, "s8 -1x1");
      chk("s8 -1x1 value", get_res(0), 128'hFFFF);
      clear_op(0, "s8");
      run_op(0, 64'h7F, 64'h80, 1'b1, "s8 127x-128");
      chk("s8 127x-128 value", get_res(0), 128'hC080);
      clear_op(0, "s8");
      run_op(0, 64'h00, 64'hB3, 1'b1, "s8 0x-77");
      chk("s8 0x-77 value", get_res(0), 128'h0);
      clear_op(0, "s8");

      run_op(2, '1, '1, 1'b0, "u64 max^2");
      chk("u64 max^2 value", get_res(2), 128'hFFFFFFFFFFFFFFFE_0000000000000001);
      clear_op(2, "u64");
      run_op(2, '1, '1, 1'b1, "s64 -1^2");
      chk("s64 -1^2 value", get_res(2), 128'h1);
      clear_op(2, "s64");

      // Abort on the third EXEC cycle, then a clean restart
      set_ops(0, 64'd9, 64'd9, 1'b0);
      start[0] = 1'b1;
      tick;
      start[0] = 1'b0;
      tick;
      tick;
      chk("abort pre busy", 128'(busy[0]), 128'd1);
      clr[0] = 1'b1;
      tick;
      clr[0] = 1'b0;
      chk("abort busy", 128'(busy[0]), 128'd0);
      chk("abort done", 128'(done[0]), 128'd0);
      chk("abort result", get_res(0), 128'd0);
      run_op(0, 64'd3, 64'd5, 1'b0, "after abort 3x5");
      chk("after abort value", get_res(0), 128'h000F);
      clear_op(0, "after abort");

      // Asynchronous reset between edges while in EXEC
      set_ops(0, 64'hA5, 64'h5A, 1'b1);
      start[0] = 1'b1;
      tick;
      start[0] = 1'b0;
      tick;
      #3;
      reset_n = 1'b0;
      #1;
      chk("async rst busy", 128'(busy[0]), 128'd0);
      chk("async rst done", 128'(done[0]), 128'd0);
      chk("async rst result", get_res(0), 128'd0);
      reset_n = 1'b1;
      tick;
      chk("post rst busy", 128'(busy[0]), 128'd0);

      start[0] = 1'b1;
      clr[0] = 1'b1;
      tick;
      chk("start+clear busy", 128'(busy[0]), 128'd0);
      tick;
      chk("start+clear busy2", 128'(busy[0]), 128'd0);
      chk("start+clear done", 128'(done[0]), 128'd0);
      start[0] = 1'b0;
      clr[0] = 1'b0;
      tick;

      for (int i = 0; i < 800; i++) begin
         run_op(0, rnd(8), rnd(8), 1'($urandom_range(0, 1)), $sformatf("rand8 #%0d", i));
         clear_op(0, "rand8");
      end
      for (int i = 0; i < 500; i++) begin
         run_op(1, rnd(16), rnd(16), 1'($urandom_range(0, 1)), $sformatf("rand16 #%0d", i));
         clear_op(1, "rand16");
      end
      for (int i = 0; i < 300; i++) begin
         run_op(2, rnd(64), rnd(64), 1'($urandom_range(0, 1)), $sformatf("rand64 #%0d", i));
         clear_op(2, "rand64");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
